// File: rtl/iguana_pinmux.sv
// iguana_pinmux: NumPins x NumFuncs pad router with break-before-make switching.
// Optional input synchronizer chain: define IGUANA_PINMUX_SYNC_EN.
module iguana_pinmux #(
    parameter int NumPins         = 8,
    parameter int NumFuncs        = 4,
    parameter int SwitchGapCycles = 4,
    parameter int SyncStages      = 2,
    parameter logic [NumFuncs*NumPins-1:0] FuncIdleIn = '0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 cfg_valid_i,
    output logic                                 cfg_ready_o,
    input  logic [$clog2(NumPins)-1:0]           cfg_pin_i,
    input  logic [$clog2(NumFuncs)-1:0]          cfg_func_i,
    output logic [NumPins*$clog2(NumFuncs)-1:0]  sel_o,
    output logic                                 busy_o,
    input  logic [NumFuncs*NumPins-1:0]          func_out_i,
    input  logic [NumFuncs*NumPins-1:0]          func_oe_i,
    output logic [NumFuncs*NumPins-1:0]          func_in_o,
    input  logic [NumPins-1:0]                   pad_i,
    output logic [NumPins-1:0]                   pad_o,
    output logic [NumPins-1:0]                   pad_en_o
);

    localparam int PW = $clog2(NumPins);
    localparam int FW = $clog2(NumFuncs);
    localparam int CW = (SwitchGapCycles > 0) ? $clog2(SwitchGapCycles + 1) : 1;

    localparam logic [PW:0] PIN_LIM = (PW+1)'(NumPins);
    localparam logic [FW:0] FUNC_LIM = (FW+1)'(NumFuncs);
    localparam logic [CW-1:0] CNT_INIT =
        CW'((SwitchGapCycles > 0) ? SwitchGapCycles - 1 : 0);

    localparam logic ACTIVE = 1'b0;
    localparam logic GAP    = 1'b1;

    logic [FW-1:0] sel   [NumPins];
    logic          state [NumPins];
    logic [CW-1:0] cnt   [NumPins];
    logic [NumPins-1:0] pin_in;

    logic pin_ok;
    logic func_ok;
    logic take;

    assign pin_ok  = {1'b0, cfg_pin_i} < PIN_LIM;
    assign func_ok = {1'b0, cfg_func_i} < FUNC_LIM;

    // Out-of-range pins are always ready so the request drains.
    always_comb begin
        cfg_ready_o = 1'b1;
        for (int p = 0; p < NumPins; p++) begin
            if (cfg_pin_i == PW'(p)) begin
                cfg_ready_o = (state[p] == ACTIVE);
            end
        end
    end

    assign take = cfg_valid_i && cfg_ready_o && pin_ok && func_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NumPins; p++) begin
                sel[p]   <= '0;
                state[p] <= ACTIVE;
                cnt[p]   <= '0;
            end
        end else begin
            for (int p = 0; p < NumPins; p++) begin
                if (state[p] == GAP) begin
                    if (cnt[p] == '0) begin
                        state[p] <= ACTIVE;
                    end else begin
                        cnt[p] <= cnt[p] - 1'b1;
                    end
                end else if (take && cfg_pin_i == PW'(p) &&
                             cfg_func_i != sel[p]) begin
                    sel[p] <= cfg_func_i;
                    if (SwitchGapCycles > 0) begin
                        state[p] <= GAP;
                        cnt[p]   <= CNT_INIT;
                    end
                end
            end
        end
    end

`ifdef IGUANA_PINMUX_SYNC_EN
    logic [SyncStages-1:0] sync [NumPins];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NumPins; p++) begin
                sync[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NumPins; p++) begin
                sync[p] <= {sync[p][SyncStages-2:0], pad_i[p]};
            end
        end
    end

    always_comb begin
        pin_in = '0;
        for (int p = 0; p < NumPins; p++) begin
            pin_in[p] = sync[p][SyncStages-1];
        end
    end
`else
    assign pin_in = pad_i;
`endif

    always_comb begin
        pad_o     = '0;
        pad_en_o  = '0;
        func_in_o = FuncIdleIn;
        sel_o     = '0;
        busy_o    = 1'b0;
        for (int p = 0; p < NumPins; p++) begin
            sel_o[p*FW +: FW] = sel[p];
            busy_o = busy_o | (state[p] == GAP);
            for (int f = 0; f < NumFuncs; f++) begin
                if (state[p] == ACTIVE && sel[p] == FW'(f)) begin
                    pad_o[p]    = func_out_i[f*NumPins+p];
                    pad_en_o[p] = func_oe_i[f*NumPins+p];
                    func_in_o[f*NumPins+p] = pin_in[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_iguana_pinmux.sv
// Directed bench for iguana_pinmux: 9 pins, 3 functions, 4-cycle gap,
// so that pin index 9 and function index 3 are out of range.
module tb_iguana_pinmux;

    localparam int NP = 9;
    localparam int NF = 3;
    localparam int FW = 2;
    localparam logic [NF*NP-1:0] IDLE = 27'd1 << 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_valid = 1'b0;
    logic cfg_ready;
    logic [3:0] cfg_pin = '0;
    logic [1:0] cfg_func = '0;
    logic [NP*FW-1:0] sel;
    logic busy;
    logic [NF*NP-1:0] func_out;
    logic [NF*NP-1:0] func_oe;
    logic [NF*NP-1:0] func_in;
    logic [NP-1:0] pad_in = '0;
    logic [NP-1:0] pad_out;
    logic [NP-1:0] pad_en;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    iguana_pinmux #(
        .NumPins(NP),
        .NumFuncs(NF),
        .SwitchGapCycles(4),
        .SyncStages(2),
        .FuncIdleIn(IDLE)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .cfg_valid_i(cfg_valid),
        .cfg_ready_o(cfg_ready),
        .cfg_pin_i(cfg_pin),
        .cfg_func_i(cfg_func),
        .sel_o(sel),
        .busy_o(busy),
        .func_out_i(func_out),
        .func_oe_i(func_oe),
        .func_in_o(func_in),
        .pad_i(pad_in),
        .pad_o(pad_out),
        .pad_en_o(pad_en)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] pin, input logic [1:0] func);
        cfg_pin   = pin;
        cfg_func  = func;
        cfg_valid = 1'b1;
        #1;
    endtask

    initial begin
        func_out = {9'h15D, 9'h1C3, 9'h0A5};
        func_oe  = {9'h0F8, 9'h1FF, 9'h1FF};
        #12;
        check("rst_pad", 32'(pad_out), 32'h0A5);
        rst_n = 1'b1;
        tick();
        tick();
        check("rel_pad", 32'(pad_out), 32'h0A5);
        check("rel_en", 32'(pad_en), 32'h1FF);
        check("rel_sel", 32'(sel), 32'h0);
        check("rel_busy", 32'(busy), 32'h0);
        check("rel_rdy", 32'(cfg_ready), 32'h1);

        check("idle_f1p1", 32'(func_in[10]), 32'h1);
        check("own_f0p1", 32'(func_in[1]), 32'h0);
        pad_in[1] = 1'b1;
`ifdef IGUANA_PINMUX_SYNC_EN
        #1;
        check("sync0", 32'(func_in[1]), 32'h0);
        tick();
        check("sync1", 32'(func_in[1]), 32'h0);
        tick();
        check("sync2", 32'(func_in[1]), 32'h1);
`else
        #1;
        check("comb_in", 32'(func_in[1]), 32'h1);
`endif
        check("idle_hold", 32'(func_in[10]), 32'h1);
        pad_in[0] = 1'b1;
        tick();
        tick();

        req(4'd0, 2'd1);
        check("sw_rdy", 32'(cfg_ready), 32'h1);
        tick();
        cfg_valid = 1'b0;
        check("t1_en0", 32'(pad_en[0]), 32'h0);
        check("t1_pad0", 32'(pad_out[0]), 32'h0);
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_sel0", 32'(sel[1:0]), 32'h1);
        check("t1_f0in", 32'(func_in[0]), 32'h0);
        check("t1_f1in", 32'(func_in[9]), 32'h0);
        tick();
        check("t2_busy", 32'(busy), 32'h1);
        req(4'd3, 2'd2);
        check("t2_rdy3", 32'(cfg_ready), 32'h1);
        tick();
        check("t3_sel3", 32'(sel[7:6]), 32'h2);
        check("t3_en3", 32'(pad_en[3]), 32'h0);
        req(4'd0, 2'd2);
        check("t3_rdy0", 32'(cfg_ready), 32'h0);
        tick();
        check("t4_rdy0", 32'(cfg_ready), 32'h0);
        check("t4_en0", 32'(pad_en[0]), 32'h0);
        tick();
        check("t5_rdy0", 32'(cfg_ready), 32'h1);
        check("t5_en0", 32'(pad_en[0]), 32'h1);
        check("t5_pad0", 32'(pad_out[0]), 32'h1);
        check("t5_f1in", 32'(func_in[9]), 32'h1);
        check("t5_busy", 32'(busy), 32'h1);
        tick();
        cfg_valid = 1'b0;
        check("t6_en0", 32'(pad_en[0]), 32'h0);
        check("t6_sel0", 32'(sel[1:0]), 32'h2);
        check("t6_en3", 32'(pad_en[3]), 32'h0);
        tick();
        check("t7_en3", 32'(pad_en[3]), 32'h1);
        check("t7_pad3", 32'(pad_out[3]), 32'h1);
        tick();
        tick();
        check("t9_busy", 32'(busy), 32'h1);
        tick();
        check("t10_busy", 32'(busy), 32'h0);
        check("t10_pad", 32'(pad_out), 32'h0AD);
        check("t10_en", 32'(pad_en), 32'h1FE);

        req(4'd2, 2'd0);
        check("same_rdy", 32'(cfg_ready), 32'h1);
        tick();
        cfg_valid = 1'b0;
        check("same_sel", 32'(sel), 32'h00082);
        check("same_busy", 32'(busy), 32'h0);
        req(4'd9, 2'd1);
        check("pin9_rdy", 32'(cfg_ready), 32'h1);
        tick();
        cfg_valid = 1'b0;
        check("pin9_sel", 32'(sel), 32'h00082);
        check("pin9_busy", 32'(busy), 32'h0);
        req(4'd2, 2'd3);
        check("f3_rdy", 32'(cfg_ready), 32'h1);
        tick();
        cfg_valid = 1'b0;
        check("f3_sel", 32'(sel), 32'h00082);
        check("f3_busy", 32'(busy), 32'h0);
        check("f3_en", 32'(pad_en), 32'h1FE);
        check("f3_pad", 32'(pad_out), 32'h0AD);

        req(4'd5, 2'd1);
        tick();
        cfg_valid = 1'b0;
        tick();
        check("g5_en5", 32'(pad_en[5]), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_sel", 32'(sel), 32'h0);
        check("ar_en", 32'(pad_en), 32'h1FF);
        check("ar_pad", 32'(pad_out), 32'h0A5);
        check("ar_busy", 32'(busy), 32'h0);
        #5;
        rst_n = 1'b1;
        tick();
        check("post_busy", 32'(busy), 32'h0);
        check("post_rdy", 32'(cfg_ready), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/iguana_pinmux.md
Name: iguana_pinmux

Overview:
- Parametrised pad multiplexer for the iguana SoC periphery.
- Replaces the fixed GPIO/USB override mux with a generic NumPins x NumFuncs router. Function 0 is always GPIO.
- Each pin's function is selected through a valid/ready config port. A pin switches with a break-before-make gap: the pad is tri-stated and the affected function inputs are held idle for a configurable number of cycles.
- Sits between cheshire_soc peripheral pin bundles and the pad ring.

Parameters:
- NumPins, 8, number of multiplexed pads.
- NumFuncs, 4, functions per pin; function 0 = GPIO; must be >= 2.
- SwitchGapCycles, 4, cycles a pin is tri-stated when its function changes; 0 = immediate switch.
- SyncStages, 2, input synchronizer depth (only with optional feature); must be >= 2.
- FuncIdleIn, '0, NumFuncs*NumPins bit vector: input value a function sees on a pin it does not own (e.g. USB D+ idle = 1).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; asynchronous, active-low. Sole clock and reset: one clock; reset is asynchronous and active-low.
- cfg_valid_i  in  1  config request valid.
- cfg_ready_o  out  1  config request ready.
- cfg_pin_i  in  $clog2(NumPins)  target pin index.
- cfg_func_i  in  $clog2(NumFuncs)  requested function.
- sel_o  out  NumPins*$clog2(NumFuncs)  current selection per pin (readback).
- busy_o  out  1  any pin in gap.
- func_out_i  in  NumFuncs*NumPins  function output data, index f*NumPins+p.
- func_oe_i  in  NumFuncs*NumPins  function output enables.
- func_in_o  out  NumFuncs*NumPins  pad input value routed to each function.
- pad_i  in  NumPins  pad input.
- pad_o  out  NumPins  pad output.
- pad_en_o  out  NumPins  pad output enable.

Behaviour:
- Per-pin state: sel[p] (register), state[p] in {ACTIVE, GAP}, gap counter cnt[p] of width $clog2(SwitchGapCycles+1).
- Reset values:
  - sel=0, state=ACTIVE, cnt=0, synchronizer flops=0, busy_o=0, cfg_ready_o=1.
  - pad_o/pad_en_o follow function 0 combinationally.
- Config handshake:
  - cfg_ready_o = (state[cfg_pin_i]==ACTIVE); combinational in cfg_pin_i.
  - A transfer occurs when valid && ready at a rising edge.
  - cfg_pin_i >= NumPins: ready=1; transfer accepted and dropped, no state change.
  - cfg_func_i >= NumFuncs: accepted and dropped, no state change.
  - cfg_func_i == sel[p]: accepted, no state change, no gap.
- Switch, for a transfer at edge T:
  - sel[p] takes the new value at T; sel_o shows it from cycle T+1.
  - If SwitchGapCycles>0: state[p]=GAP and cnt=SwitchGapCycles-1 at T.
  - GAP: cnt decrements each cycle; at cnt==0, state returns to ACTIVE.
  - The pin is in GAP for cycles T+1..T+SwitchGapCycles.
  - The new function owns the pin from cycle T+1+SwitchGapCycles.
  - SwitchGapCycles==0: the new function owns the pin from T+1.
- Output routing:
  - ACTIVE: pad_o[p]=func_out_i[sel,p]; pad_en_o[p]=func_oe_i[sel,p].
  - GAP: pad_o[p]=0; pad_en_o[p]=0.
- Input routing:
  - func_in_o[f,p] = pin input value when (state[p]==ACTIVE && sel[p]==f); otherwise FuncIdleIn[f,p].
  - During GAP, all functions see idle values on that pin.
- busy_o = OR over state[p]==GAP. It is registered-state-derived, with no combinational input path.
- Different pins switch independently and may be in GAP concurrently. A request to a pin in GAP stalls (ready=0) until it returns to ACTIVE.
- Reset asserted mid-gap: immediately returns to sel=0, ACTIVE; pad driven by GPIO again.

Optional Feature:
- Macro IGUANA_PINMUX_SYNC_EN.
- Defined: pad_i passes through a SyncStages-deep flop chain per pin before input routing. Input latency is SyncStages cycles; the chain resets to 0.
- Undefined: pad_i is routed combinationally; zero latency; SyncStages ignored.
- Output path, config and gap behaviour are identical in both builds.

Test Plan:
- Reset release, NumPins=8, all func_oe_i[0,*]=1, func_out_i[0,*]=8'hA5 -> pad_o=8'hA5, pad_en_o=8'hFF, sel_o=0, busy_o=0, cfg_ready_o=1.
- cfg pin 0 -> func 1 at edge T, SwitchGapCycles=4 -> pad_en_o[0]=0 and busy_o=1 for exactly cycles T+1..T+4; function 1 drives pad 0 from T+5; func_in_o[0,0]=FuncIdleIn from T+1.
- Second request to pin 0 at T+2 -> cfg_ready_o=0 until T+5; accepted at T+5; new gap T+6..T+9. Concurrent request to pin 3 at T+2 -> accepted immediately.
- Same-function request (pin 2 -> func 0), pin index 9, and func index >= NumFuncs -> all accepted in one cycle; sel_o and pad outputs unchanged; busy_o stays 0.
- FuncIdleIn[1,1]=1, pin 1 on func 0, pad_i[1]=0 -> func_in_o[1,1]=1, func_in_o[0,1]=0. With IGUANA_PINMUX_SYNC_EN, a pad_i[1] toggle appears on func_in_o[0,1] after exactly 2 cycles.
- Assert rst_ni asynchronously at cycle T+2 of a pin-5 gap -> in the same cycle sel=0 and pad_en_o[5]=func_oe_i[0,5]; busy_o=0 after reset.
